branch_resolve: RTL

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/core_pkg.sv | 36 +++
 rtl/br_cond_eval.sv | 35 +++
 rtl/branch_resolve.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the branch resolution slice.
//
// Contents:
//   CORE_PC_W            PC/target width carried in the slot record
//   OP_JUMP..OP_JUMPNE   branch opcode encodings seen in execute
//   slot_t               pipeline slot record {valid, pc, pred_taken, pred_target}
//   br_state_e           redirect/flush FSM states
//   next_seq_pc()        fall-through PC, wraps modulo 2^CORE_PC_W
package core_pkg;

  localparam int unsigned CORE_PC_W = 16;

  localparam logic [3:0] OP_JUMP   = 4'h6;  // unconditional
  localparam logic [3:0] OP_JUMPL  = 4'h7;  // taken on lflag
  localparam logic [3:0] OP_JUMPG  = 4'h8;  // taken on gflag
  localparam logic [3:0] OP_JUMPE  = 4'h9;  // taken on zflag
  localparam logic [3:0] OP_JUMPNE = 4'hA;  // taken on ~zflag

  typedef struct packed {
    logic                 valid;
    logic [CORE_PC_W-1:0] pc;
    logic                 pred_taken;
    logic [CORE_PC_W-1:0] pred_target;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH1 = 2'd1,
    ST_FLUSH2 = 2'd2
  } br_state_e;

  function automatic logic [CORE_PC_W-1:0] next_seq_pc(input logic [CORE_PC_W-1:0] pc);
    return pc + CORE_PC_W'(1);
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: maps the execute-stage opcode and condition
// flags to {is_branch, taken}. Purely combinational.
//
// Ports:
//   opcode_i   [3:0]  opcode of the instruction in execute
//   lflag_i           less-than flag
//   gflag_i           greater-than flag
//   zflag_i           zero/equal flag
//   is_branch_o       opcode is one of JUMP..JUMPNE
//   taken_o           resolved direction (0 for non-branches)
module br_cond_eval
  import core_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       lflag_i,
  input  logic       gflag_i,
  input  logic       zflag_i,
  output logic       is_branch_o,
  output logic       taken_o
);

  always_comb begin
    is_branch_o = 1'b1;
    taken_o     = 1'b0;
    case (opcode_i)
      OP_JUMP:   taken_o = 1'b1;
      OP_JUMPL:  taken_o = lflag_i;
      OP_JUMPG:  taken_o = gflag_i;
      OP_JUMPE:  taken_o = zflag_i;
      OP_JUMPNE: taken_o = ~zflag_i;
      default:   is_branch_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution unit. Carries fetched instructions through a DEC and an
// EX slot, resolves branches in EX against the predictor's guess, drives a
// two-cycle flush plus a one-cycle redirect on a mispredict, and queues a
// predictor update for every resolved branch in a one-entry buffer.
//
// Optional feature macro: BRANCH_RESOLVE_PERF_EN adds saturating 16-bit
// counters br_count (resolved branches) and mp_count (mispredicts).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   fetch_valid/pc           instruction entering DEC this cycle
//   pred_taken/pred_target   predictor guess for fetch_pc
//   stall                    hold DEC/EX slots this cycle
//   ex_opcode, ex_target     opcode and computed target of the EX instruction
//   lflag, gflag, zflag      condition flags for EX
//   upd_ready                predictor accepts the pending update
//   flush                    kill DEC/fetch (two cycles after a mispredict)
//   redirect_valid/pc        one-cycle strobe with the corrected fetch PC
//   upd_valid/pc/target/taken  predictor update (valid/ready handshake)
//   stall_req                update buffer full and not draining
//   br_count, mp_count       only with BRANCH_RESOLVE_PERF_EN
//
// Update handshake: an entry is presented while upd_valid=1 and leaves on a
// cycle where upd_valid and upd_ready are both 1; while upd_valid=1 and
// upd_ready=0 every upd_* field is held. Upstream must honour stall_req by
// raising stall, otherwise a new resolution would overwrite the held entry.
//
// The slot record width is core_pkg::CORE_PC_W, so PC_W must equal it.
module branch_resolve
  import core_pkg::*;
#(
  parameter int unsigned PC_W = CORE_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            pred_taken,
  input  logic [PC_W-1:0] pred_target,
  input  logic            stall,
  input  logic [3:0]      ex_opcode,
  input  logic [PC_W-1:0] ex_target,
  input  logic            lflag,
  input  logic            gflag,
  input  logic            zflag,
  input  logic            upd_ready,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            redirect_valid,
  output logic            upd_valid,
  output logic [PC_W-1:0] upd_pc,
  output logic [PC_W-1:0] upd_target,
  output logic            upd_taken,
  output logic            stall_req
`ifdef BRANCH_RESOLVE_PERF_EN
  ,
  output logic [15:0]     br_count,
  output logic [15:0]     mp_count
`endif
);

  slot_t           dec_q, dec_d;
  slot_t           ex_q, ex_d;
  br_state_e       state_q;
  logic            flush_q;
  logic            redirect_valid_q;
  logic [PC_W-1:0] redirect_pc_q;

  logic            upd_valid_q, upd_valid_d;
  logic [PC_W-1:0] upd_pc_q, upd_pc_d;
  logic [PC_W-1:0] upd_target_q, upd_target_d;
  logic            upd_taken_q, upd_taken_d;

  logic            is_branch;
  logic            taken;
  logic            resolve;
  logic            mispredict;
  logic            enq;
  logic            pop;

  br_cond_eval u_cond (
    .opcode_i    (ex_opcode),
    .lflag_i     (lflag),
    .gflag_i     (gflag),
    .zflag_i     (zflag),
    .is_branch_o (is_branch),
    .taken_o     (taken)
  );

  // Resolution only happens in IDLE, so FLUSH1/FLUSH2 never evaluate a
  // mispredict even if a stale EX entry were present.
  assign resolve    = ex_q.valid && !stall && (state_q == ST_IDLE);
  // A non-branch predicted taken falls out of the first term (taken=0).
  assign mispredict = resolve &&
                      ((taken != ex_q.pred_taken) ||
                       (taken && (ex_target != ex_q.pred_target)));
  assign enq        = resolve && is_branch;
  assign pop        = upd_valid_q && upd_ready;

  // DEC/EX slots. A mispredict kills both slots, including the instruction
  // being fetched in the same cycle.
  always_comb begin
    dec_d = dec_q;
    ex_d  = ex_q;
    if (!stall) begin
      ex_d              = dec_q;
      dec_d.valid       = fetch_valid && !flush_q;
      dec_d.pc          = fetch_pc;
      dec_d.pred_taken  = pred_taken;
      dec_d.pred_target = pred_target;
    end
    if (mispredict) begin
      dec_d.valid = 1'b0;
      ex_d.valid  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_q <= '0;
      ex_q  <= '0;
    end else begin
      dec_q <= dec_d;
      ex_q  <= ex_d;
    end
  end

  // Redirect/flush FSM; flush is high in FLUSH1 and FLUSH2, the redirect
  // strobe only in the first of them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mispredict) begin
            state_q          <= ST_FLUSH1;
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= taken ? ex_target : next_seq_pc(ex_q.pc);
          end
        end
        ST_FLUSH1: state_q <= ST_FLUSH2;
        ST_FLUSH2: begin
          state_q <= ST_IDLE;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  // One-entry update buffer. Enqueue wins over pop so a same-cycle
  // pop+enqueue reloads the entry with no bubble.
  always_comb begin
    upd_valid_d  = upd_valid_q;
    upd_pc_d     = upd_pc_q;
    upd_target_d = upd_target_q;
    upd_taken_d  = upd_taken_q;
    if (pop) begin
      upd_valid_d = 1'b0;
    end
    if (enq) begin
      upd_valid_d  = 1'b1;
      upd_pc_d     = ex_q.pc;
      upd_target_d = ex_target;
      upd_taken_d  = taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
    end else begin
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_target_q <= upd_target_d;
      upd_taken_q  <= upd_taken_d;
    end
  end

`ifdef BRANCH_RESOLVE_PERF_EN
  logic [15:0] br_count_q;
  logic [15:0] mp_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      if (enq && (br_count_q != 16'hFFFF)) begin
        br_count_q <= br_count_q + 16'd1;
      end
      if (mispredict && (mp_count_q != 16'hFFFF)) begin
        mp_count_q <= mp_count_q + 16'd1;
      end
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;
`endif

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_target     = upd_target_q;
  assign upd_taken      = upd_taken_q;
  assign stall_req      = upd_valid_q && !upd_ready;

endmodule
